imm_encoder: RTL and testbench

Immediate encoder for the RISC-V datapath. It is the inverse of the immediate sign-extension stage: it takes a 32-bit immediate and an immediate type, and scatters the immediate bits into the immediate fields of an instruction word. The non-immediate fields come from a base instruction. It sits on the instruction-generation path (self-test, trap stubs, instruction-memory preload) and feeds a valid/ready consumer through a 2-entry output FIFO. It also range-checks each immediate and keeps encode and error counters.

---
 rtl/imm_encoder.sv | 142 ++++++++++++++
 tb/tb_imm_encoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: scatters a 32-bit immediate into the I/S/B/J immediate fields of a
// base instruction and queues the result in a 2-entry valid/ready output FIFO.
// Also keeps a count of output handshakes and of range-errored requests.
// Optional feature macro: IMM_RANGE_CHECK_EN. When it is defined, range checking,
// out_err and err_count are live. When it is undefined, out_err and err_count are tied to 0.
module imm_encoder #(
    parameter int COUNT_W = 16,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        base_instr,
    input  logic [31:0]        imm,
    input  logic [1:0]         imm_src,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_err,
    output logic [COUNT_W-1:0] enc_count,
    output logic [ERR_W-1:0]   err_count
);

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_type_t;

    logic [31:0] enc_instr;
    logic        enc_err;
    logic [31:0] fifo_instr [2];
    logic        fifo_err   [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occupancy;
    logic        push;
    logic        pop;

    // Overwrite only the immediate fields of the selected type; all other bits pass through from base_instr.
    always_comb begin
        enc_instr = base_instr;
        case (imm_type_t'(imm_src))
            IMM_I: begin
                enc_instr[31:20] = imm[11:0];
            end
            IMM_S: begin
                enc_instr[31:25] = imm[11:5];
                enc_instr[11:7]  = imm[4:0];
            end
            IMM_B: begin
                enc_instr[31]    = imm[12];
                enc_instr[30:25] = imm[10:5];
                enc_instr[11:8]  = imm[4:1];
                enc_instr[7]     = imm[11];
            end
            default: begin
                enc_instr[31]    = imm[20];
                enc_instr[30:21] = imm[10:1];
                enc_instr[20]    = imm[11];
                enc_instr[19:12] = imm[19:12];
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s = $signed(imm);

    // Flag immediates that do not fit the field, and odd offsets for branches and jumps.
    // A flagged request is still encoded from its truncated bits.
    always_comb begin
        enc_err = 1'b0;
        case (imm_type_t'(imm_src))
            IMM_I, IMM_S: enc_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            IMM_B:        enc_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
            default:      enc_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
        endcase
    end
`else
    assign enc_err = 1'b0;
`endif

    assign in_ready  = (occupancy != 2'd2);
    assign out_valid = (occupancy != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign out_err   = out_valid ? fifo_err[rd_ptr] : 1'b0;

    // Two-entry FIFO. The 1-bit pointers toggle to wrap. A push and a pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            occupancy     <= 2'd0;
            fifo_instr[0] <= 32'h0;
            fifo_instr[1] <= 32'h0;
            fifo_err[0]   <= 1'b0;
            fifo_err[1]   <= 1'b0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= enc_instr;
                fifo_err[wr_ptr]   <= enc_err;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Count output handshakes. The count wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count <= '0;
        end else if (pop) begin
            enc_count <= enc_count + COUNT_W'(1);
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    // Count accepted requests that carry a range error. The count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (push && enc_err && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vectors with hand-computed expected words for imm_encoder.
// A second instance with narrow counters shares the same stimulus to exercise wrap and saturation.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base_instr;
    logic [31:0] imm;
    logic [1:0]  imm_src;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    logic        sm_in_ready;
    logic        sm_out_valid;
    logic [31:0] sm_out_instr;
    logic        sm_out_err;
    logic [3:0]  sm_enc_count;
    logic [1:0]  sm_err_count;

    int total = 0;
    int bad   = 0;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    imm_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .base_instr (base_instr),
        .imm        (imm),
        .imm_src    (imm_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .enc_count  (enc_count),
        .err_count  (err_count)
    );

    imm_encoder #(.COUNT_W(4), .ERR_W(2)) dut_small (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (sm_in_ready),
        .base_instr (base_instr),
        .imm        (imm),
        .imm_src    (imm_src),
        .out_valid  (sm_out_valid),
        .out_ready  (out_ready),
        .out_instr  (sm_out_instr),
        .out_err    (sm_out_err),
        .enc_count  (sm_enc_count),
        .err_count  (sm_err_count)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Expected error-related value: live only when range checking is compiled in.
    function automatic logic [31:0] exp_err(input logic [31:0] v);
        return CHK ? v : 32'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] base, input logic [31:0] value,
                                 input logic [1:0] src, input logic ready);
        in_valid   = valid;
        base_instr = base;
        imm        = value;
        imm_src    = src;
        out_ready  = ready;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Directed sequence: reset, per-type encodings, range boundaries, backpressure, reset while busy, wrap.
    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        tick;
        tick;
        reset = 1'b0;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_enc_count", 32'(enc_count), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);

        $display("[TB] back-to-back encodings");
        applyStimulus(1'b1, 32'h00000013, 32'hFFFFFFFF, 2'b00, 1'b1);
        tick;
        checkOutput("i_valid", 32'(out_valid), 32'd1);
        checkOutput("i_instr", out_instr, 32'hFFF00013);
        checkOutput("i_err", 32'(out_err), 32'd0);
        applyStimulus(1'b1, 32'h00002023, 32'd8, 2'b01, 1'b1);
        tick;
        checkOutput("s_instr", out_instr, 32'h00002423);
        applyStimulus(1'b1, 32'h00000063, 32'hFFFFFFFC, 2'b10, 1'b1);
        tick;
        checkOutput("b_instr", out_instr, 32'hFE000EE3);
        checkOutput("b_err", 32'(out_err), 32'd0);
        applyStimulus(1'b1, 32'h0000006F, 32'h00000800, 2'b11, 1'b1);
        tick;
        checkOutput("j_instr", out_instr, 32'h0010006F);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        tick;
        checkOutput("drain_valid", 32'(out_valid), 32'd0);
        checkOutput("enc_count_4", 32'(enc_count), 32'd4);

        $display("[TB] range boundaries");
        applyStimulus(1'b1, 32'h00000013, 32'd2048, 2'b00, 1'b1);
        tick;
        checkOutput("i2048_instr", out_instr, 32'h80000013);
        checkOutput("i2048_err", 32'(out_err), exp_err(32'd1));
        checkOutput("i2048_errcnt", 32'(err_count), exp_err(32'd1));
        applyStimulus(1'b1, 32'h00000063, 32'd3, 2'b10, 1'b1);
        tick;
        checkOutput("b3_instr", out_instr, 32'h00000163);
        checkOutput("b3_err", 32'(out_err), exp_err(32'd1));
        checkOutput("b3_errcnt", 32'(err_count), exp_err(32'd2));
        applyStimulus(1'b1, 32'h00000013, 32'hFFFFF800, 2'b00, 1'b1);
        tick;
        checkOutput("im2048_instr", out_instr, 32'h80000013);
        checkOutput("im2048_err", 32'(out_err), 32'd0);
        applyStimulus(1'b1, 32'h00000063, 32'd4094, 2'b10, 1'b1);
        tick;
        checkOutput("b4094_instr", out_instr, 32'h7E000FE3);
        checkOutput("b4094_err", 32'(out_err), 32'd0);
        applyStimulus(1'b1, 32'h0000006F, 32'hFFF00000, 2'b11, 1'b1);
        tick;
        checkOutput("jmin_instr", out_instr, 32'h8000006F);
        checkOutput("jmin_err", 32'(out_err), 32'd0);
        applyStimulus(1'b1, 32'h0000006F, 32'h00100000, 2'b11, 1'b1);
        tick;
        checkOutput("jover_instr", out_instr, 32'h8000006F);
        checkOutput("jover_err", 32'(out_err), exp_err(32'd1));
        checkOutput("jover_errcnt", 32'(err_count), exp_err(32'd3));
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        tick;
        checkOutput("enc_count_10", 32'(enc_count), 32'd10);
        checkOutput("sm_enc_count_10", 32'(sm_enc_count), 32'd10);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h00002023, 32'd8, 2'b01, 1'b0);
        tick;
        checkOutput("bp1_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp1_instr", out_instr, 32'h00002423);
        applyStimulus(1'b1, 32'h00000013, 32'd5, 2'b00, 1'b0);
        tick;
        checkOutput("bp2_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp2_instr", out_instr, 32'h00002423);
        applyStimulus(1'b1, 32'h0000006F, 32'h00000800, 2'b11, 1'b0);
        tick;
        checkOutput("bp3_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp3_hold_instr", out_instr, 32'h00002423);
        checkOutput("bp3_hold_count", 32'(enc_count), 32'd10);
        applyStimulus(1'b1, 32'h0000006F, 32'h00000800, 2'b11, 1'b1);
        tick;
        checkOutput("bp4_instr", out_instr, 32'h00500013);
        checkOutput("bp4_in_ready", 32'(in_ready), 32'd1);
        tick;
        checkOutput("bp5_instr", out_instr, 32'h0010006F);
        checkOutput("bp5_valid", 32'(out_valid), 32'd1);
        checkOutput("bp5_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        tick;
        checkOutput("bp6_valid", 32'(out_valid), 32'd0);
        checkOutput("enc_count_13", 32'(enc_count), 32'd13);

        $display("[TB] reset while busy");
        applyStimulus(1'b1, 32'h00000013, 32'd2048, 2'b00, 1'b0);
        tick;
        applyStimulus(1'b1, 32'h00000063, 32'd3, 2'b10, 1'b0);
        tick;
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_errcnt_5", 32'(err_count), exp_err(32'd5));
        checkOutput("sm_errcnt_sat", 32'(sm_err_count), exp_err(32'd3));
        reset = 1'b1;
        applyStimulus(1'b1, 32'h00000013, 32'd5, 2'b00, 1'b1);
        tick;
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mrst_enc_count", 32'(enc_count), 32'd0);
        checkOutput("mrst_err_count", 32'(err_count), 32'd0);
        checkOutput("mrst_out_instr", out_instr, 32'h0);
        tick;
        checkOutput("mrst_no_ghost", 32'(out_valid), 32'd0);
        checkOutput("mrst_enc_hold", 32'(enc_count), 32'd0);

        $display("[TB] counter wrap and saturation");
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b1, 32'h00000013, (k < 5) ? 32'd2048 : 32'(k), 2'b00, 1'b1);
            tick;
        end
        checkOutput("wrap_last_instr", out_instr, 32'h01000013);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        tick;
        checkOutput("wrap_enc_17", 32'(enc_count), 32'd17);
        checkOutput("wrap_sm_enc_1", 32'(sm_enc_count), 32'd1);
        checkOutput("wrap_err_5", 32'(err_count), exp_err(32'd5));
        checkOutput("wrap_sm_err_3", 32'(sm_err_count), exp_err(32'd3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
